// File: rtl/pe_dot_sequencer.sv
// ----------------------------------------------------------------------------
// pe_dot_sequencer : one log-shift PE time-multiplexed into a signed dot product.
// Optional macro PE_DOT_SEQUENCER_SATURATE_EN clamps the accumulator.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe #(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int PROD_WIDTH       = INPUT_BIT_WIDTH + (2 ** WEIGHT_BIT_WIDTH) / 2
) (
  input  logic [INPUT_BIT_WIDTH-1:0]  act,
  input  logic [WEIGHT_BIT_WIDTH-1:0] weight,
  output logic [PROD_WIDTH-1:0]       prod
);
  logic [PROD_WIDTH-1:0] mag;

  always_comb begin
    mag  = PROD_WIDTH'(act) << weight[WEIGHT_BIT_WIDTH-2:0];
    prod = weight[WEIGHT_BIT_WIDTH-1] ? (~mag + 1'b1) : mag;
  end
endmodule

module pe_dot_sequencer #(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int ACC_WIDTH        = 16,
  parameter int LEN_WIDTH        = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [LEN_WIDTH-1:0]        start_len,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [INPUT_BIT_WIDTH-1:0]  op_in,
  input  logic [WEIGHT_BIT_WIDTH-1:0] op_weight,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ACC_WIDTH-1:0]        res_data,
  output logic                        res_sat
);
  localparam int PROD_WIDTH = INPUT_BIT_WIDTH + (2 ** WEIGHT_BIT_WIDTH) / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_next, prod_q, prod_ext;
  logic                  prod_vld;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [PROD_WIDTH-1:0] pe_prod;
  logic                  start_fire, op_fire;

  pe #(
    .WEIGHT_BIT_WIDTH (WEIGHT_BIT_WIDTH),
    .INPUT_BIT_WIDTH  (INPUT_BIT_WIDTH),
    .PROD_WIDTH       (PROD_WIDTH)
  ) u_pe (
    .act    (op_in),
    .weight (op_weight),
    .prod   (pe_prod)
  );

  assign prod_ext   = ACC_WIDTH'($signed(pe_prod));
  assign start_fire = start_valid & start_ready;
  assign op_fire    = op_valid & op_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = (start_len == '0) ? DONE : RUN;
      end
      RUN: begin
        op_ready = 1'b1;
        if (op_valid && cnt_q == LEN_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PE_DOT_SEQUENCER_SATURATE_EN
  logic [ACC_WIDTH:0] sum_ext;
  logic               clamp;
  logic               sat_q;

  // One extra bit exposes signed overflow; its top bit gives the clamp direction.
  always_comb begin
    sum_ext = {acc_q[ACC_WIDTH-1], acc_q} + {prod_q[ACC_WIDTH-1], prod_q};
    clamp   = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    if (!clamp)                 acc_next = sum_ext[ACC_WIDTH-1:0];
    else if (sum_ext[ACC_WIDTH]) acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else                        acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sat_q <= 1'b0;
    else if (start_fire)  sat_q <= 1'b0;
    else if (prod_vld)    sat_q <= sat_q | clamp;
  end

  assign res_sat = sat_q;
`else
  assign acc_next = acc_q + prod_q;
  assign res_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      cnt_q    <= '0;
      res_data <= '0;
    end else begin
      prod_vld <= op_fire;
      if (op_fire) prod_q <= prod_ext;

      if (start_fire)    acc_q <= '0;
      else if (prod_vld) acc_q <= acc_next;

      if (start_fire)   cnt_q <= start_len;
      else if (op_fire) cnt_q <= cnt_q - LEN_WIDTH'(1);

      // DRAIN always follows the final handshake, so acc_next is the complete sum.
      if (state_q == DRAIN)                  res_data <= acc_next;
      else if (start_fire && start_len == '0) res_data <= '0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_pe_dot_sequencer.sv
// Directed self-checking bench for pe_dot_sequencer.
`default_nettype none

module tb_pe_dot_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [5:0]  start_len = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op_in = '0;
  logic [3:0]  op_weight = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_sat;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PE_DOT_SEQUENCER_SATURATE_EN
  localparam int OVF_DATA = 32767;
  localparam int OVF_SAT  = 1;
`else
  localparam int OVF_DATA = -27136;
  localparam int OVF_SAT  = 0;
`endif

  pe_dot_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_len   (start_len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_in       (op_in),
    .op_weight   (op_weight),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_sat     (res_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(res_data));
  endfunction

  task automatic send_cmd(input int len);
    int n = 0;
    start_valid = 1'b1;
    start_len   = 6'(len);
    while (!start_ready && n < 50) begin @(negedge clk); n++; end
    check("start_timeout", int'(start_ready), 1);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic send_op(input int a, input int w);
    int n = 0;
    op_valid  = 1'b1;
    op_in     = 4'(a);
    op_weight = 4'(w);
    while (!op_ready && n < 50) begin @(negedge clk); n++; end
    check("op_timeout", int'(op_ready), 1);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input int exp, input int exp_sat, input int hold);
    int n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_valid"}, int'(res_valid), 1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_data"}, sdata(), exp);
      check({tag, "_hold_sready"}, int'(start_ready), 0);
      @(negedge clk);
    end
    check({tag, "_data"}, sdata(), exp);
    check({tag, "_sat"}, int'(res_sat), exp_sat);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_sready_after"}, int'(start_ready), 1);
    check({tag, "_valid_after"}, int'(res_valid), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_sready", int'(start_ready), 1);
    check("rst_oready", int'(op_ready), 0);
    check("rst_rvalid", int'(res_valid), 0);
    check("rst_data", sdata(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-command after 2 of 5 pairs
    send_cmd(5);
    send_op(5, 4'b0011);
    send_op(3, 4'b0011);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sready", int'(start_ready), 1);
    check("midrst_oready", int'(op_ready), 0);
    check("midrst_rvalid", int'(res_valid), 0);
    check("midrst_data", sdata(), 0);
    check("midrst_sat", int'(res_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_cmd(1);
    send_op(5, 4'b0011);
    take_result("after_rst", 40, 0, 0);

    // Mixed signs, back-to-back, latency
    send_cmd(3);
    send_op(5, 4'b0011);
    send_op(3, 4'b1000);
    send_op(15, 4'b0111);
    check("mixed_lat_drain", int'(res_valid), 0);
    @(negedge clk);
    check("mixed_lat_done", int'(res_valid), 1);
    take_result("mixed", 1957, 0, 0);

    // Stalls plus backpressure, with a start pulse during RUN
    send_cmd(3);
    send_op(5, 4'b0011);
    start_valid = 1'b1;
    start_len   = 6'd2;
    @(negedge clk);
    check("stall_sready", int'(start_ready), 0);
    start_valid = 1'b0;
    @(negedge clk);
    check("stall_oready", int'(op_ready), 1);
    send_op(3, 4'b1000);
    repeat (2) @(negedge clk);
    send_op(15, 4'b0111);
    @(negedge clk);
    // op_valid during DONE must not disturb the held result
    op_valid  = 1'b1;
    op_in     = 4'd9;
    op_weight = 4'b0101;
    @(negedge clk);
    check("done_oready", int'(op_ready), 0);
    op_valid = 1'b0;
    take_result("stall", 1957, 0, 4);

    // Zero length
    send_cmd(0);
    check("zero_valid", int'(res_valid), 1);
    check("zero_oready", int'(op_ready), 0);
    take_result("zero", 0, 0, 0);

    // Overflow: 20 x 1920
    send_cmd(20);
    for (int i = 0; i < 20; i++) send_op(15, 4'b0111);
    take_result("ovf", OVF_DATA, OVF_SAT, 1);

    // Next command clears res_sat
    send_cmd(1);
    send_op(5, 4'b0011);
    check("next_sat_clear", int'(res_sat), 0);
    take_result("next", 40, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
